// File: rtl/ppu_spr_fetch_if.sv
// ppu_spr_fetch_if: secondary OAM and VRAM read buses of the sprite fetch engine
interface ppu_spr_fetch_if;
  logic [4:0]  o_soam_addr;
  logic [7:0]  i_soam_data;
  logic        o_vram_req;
  logic [13:0] o_vram_addr;
  logic        i_vram_valid;
  logic [7:0]  i_vram_data;
  modport master (output o_soam_addr, o_vram_req, o_vram_addr,
                  input  i_soam_data, i_vram_valid, i_vram_data);
  modport slave  (input  o_soam_addr, o_vram_req, o_vram_addr,
                  output i_soam_data, i_vram_valid, i_vram_data);
endinterface

// File: rtl/ppu_spr_fetch.sv
// ppu_spr_fetch: per-scanline sprite fetch, loads the eight sprite pipeline slots
module ppu_spr_fetch #(
  parameter int NUM_SLOTS = 8
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  input  logic [3:0]  i_spr_cnt,
  input  logic [7:0]  i_scanline,
  input  logic        i_spr_size,
  input  logic        i_spr_pt_sel,
  ppu_spr_fetch_if.master bus,
  output logic [2:0]  o_slot,
  output logic [7:0]  o_xcnt,
  output logic        o_xcnt_wr,
  output logic [7:0]  o_attr,
  output logic        o_attr_we,
  output logic [15:0] o_patt,
  output logic        o_patt_we,
  output logic        o_busy,
  output logic        o_done
);
  typedef enum logic [2:0] {IDLE, SOAM, FETCH_L, FETCH_H, WR_A, WR_P, DONE} state_t;
  state_t r_state, w_next;
  logic [3:0]  r_cnt;
  logic [7:0]  r_line, r_y, r_tile, r_attr, r_x, r_p0, r_p1, r_xcnt_q, r_attr_q;
  logic [15:0] r_patt_q;
  logic        r_size, r_pt;
  logic [2:0]  r_slot, r_sub, w_slot_nx;
  logic [3:0]  w_row, w_r4;
  logic        w_fill, w_last, w_plane, w_req;
  logic [13:0] w_addr;
  assign w_slot_nx = r_slot + 3'd1;
  assign w_last    = r_slot == 3'(NUM_SLOTS - 1);
  assign w_fill    = {1'b0, r_slot} < r_cnt;
  // only the low nibble of the line distance matters; evaluation guarantees range
  assign w_row     = 4'(r_line - r_y);
  assign w_r4      = r_attr[7] ? ~w_row : w_row;
  assign w_plane   = r_state == FETCH_H;
  assign w_req     = r_state == FETCH_L || r_state == FETCH_H;
  assign w_addr    = r_size ? {1'b0, r_tile[0], r_tile[7:1], w_r4[3], w_plane, w_r4[2:0]}
                            : {1'b0, r_pt, r_tile, w_plane, w_r4[2:0]};
  assign bus.o_vram_req  = w_req;
  assign bus.o_vram_addr = w_req ? w_addr : '0;
  assign bus.o_soam_addr = r_state == SOAM ? {r_slot, r_sub[1:0]} : '0;
  assign o_slot    = r_slot;
  assign o_attr_we = r_state == WR_A;
  assign o_xcnt_wr = r_state == WR_A;
  assign o_patt_we = r_state == WR_P;
  assign o_busy    = r_state != IDLE;
  assign o_done    = r_state == DONE;
  // data outputs are live during their strobe and otherwise hold the last written value
  assign o_attr    = o_attr_we ? (w_fill ? r_attr : 8'h00) : r_attr_q;
  assign o_xcnt    = o_xcnt_wr ? (w_fill ? r_x : 8'hFF) : r_xcnt_q;
  assign o_patt    = o_patt_we ? (w_fill ? {r_p1, r_p0} : 16'h0000) : r_patt_q;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = i_spr_cnt != 4'd0 ? SOAM : WR_A;
      SOAM:    if (r_sub == 3'd4) w_next = FETCH_L;
      FETCH_L: if (bus.i_vram_valid) w_next = FETCH_H;
      FETCH_H: if (bus.i_vram_valid) w_next = WR_A;
      WR_A:    w_next = WR_P;
      WR_P:    w_next = w_last ? DONE : ({1'b0, w_slot_nx} < r_cnt ? SOAM : WR_A);
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_line   <= '0;
      r_size   <= 1'b0;
      r_pt     <= 1'b0;
      r_slot   <= '0;
      r_sub    <= '0;
      r_y      <= '0;
      r_tile   <= '0;
      r_attr   <= '0;
      r_x      <= '0;
      r_p0     <= '0;
      r_p1     <= '0;
      r_xcnt_q <= '0;
      r_attr_q <= '0;
      r_patt_q <= '0;
    end else begin
      r_state  <= w_next;
      r_sub    <= r_state == SOAM ? r_sub + 3'd1 : 3'd0;
      r_xcnt_q <= o_xcnt;
      r_attr_q <= o_attr;
      r_patt_q <= o_patt;
      if (r_state == IDLE && i_start) begin
        r_cnt  <= i_spr_cnt > 4'(NUM_SLOTS) ? 4'(NUM_SLOTS) : i_spr_cnt;
        r_line <= i_scanline;
        r_size <= i_spr_size;
        r_pt   <= i_spr_pt_sel;
        r_slot <= '0;
      end
      if (r_state == WR_P && !w_last) r_slot <= w_slot_nx;
      if (r_state == SOAM) begin
        if (r_sub == 3'd1) r_y    <= bus.i_soam_data;
        if (r_sub == 3'd2) r_tile <= bus.i_soam_data;
        if (r_sub == 3'd3) r_attr <= bus.i_soam_data;
        if (r_sub == 3'd4) r_x    <= bus.i_soam_data;
      end
      if (r_state == FETCH_L && bus.i_vram_valid) r_p0 <= bus.i_vram_data;
      if (r_state == FETCH_H && bus.i_vram_valid) r_p1 <= bus.i_vram_data;
    end
  end
endmodule

// File: tb/tb_ppu_spr_fetch.sv
// tb_ppu_spr_fetch: directed checks of the sprite fetch engine against hand-computed values
module tb_ppu_spr_fetch;
  logic        clk = 1'b0, rstn, start, size, pt;
  logic [3:0]  spr_cnt;
  logic [7:0]  line;
  logic [2:0]  o_slot;
  logic [7:0]  o_xcnt, o_attr;
  logic [15:0] o_patt;
  logic        o_xcnt_wr, o_attr_we, o_patt_we, o_busy, o_done;
  logic [7:0]  soam [32];
  int          dly, wcnt, n_chk, n_fail;
  int          n_cyc, done_at, n_done, n_req, n_vlog, n_wa, n_wp, errs;
  bit          seen_done, p_req, p_val, p_wa;
  logic [13:0] p_addr;
  logic [13:0] vlog [32];
  logic [7:0]  la [8], lx [8], p_attr, p_xcnt;
  logic [15:0] lp [8], p_patt;

  ppu_spr_fetch_if bus ();

  ppu_spr_fetch dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_spr_cnt(spr_cnt),
    .i_scanline(line), .i_spr_size(size), .i_spr_pt_sel(pt), .bus(bus),
    .o_slot(o_slot), .o_xcnt(o_xcnt), .o_xcnt_wr(o_xcnt_wr), .o_attr(o_attr),
    .o_attr_we(o_attr_we), .o_patt(o_patt), .o_patt_we(o_patt_we),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.i_soam_data <= soam[bus.o_soam_addr];
  always @(posedge clk) wcnt <= (bus.o_vram_req && !bus.i_vram_valid) ? wcnt + 1 : 0;
  assign bus.i_vram_valid = bus.o_vram_req && (wcnt >= dly);
  assign bus.i_vram_data  = ~bus.o_vram_addr[7:0];

  always @(negedge clk) begin
    if (start && !o_busy) begin
      n_cyc = 0; done_at = 0; n_done = 0; n_req = 0; n_vlog = 0;
      n_wa = 0; n_wp = 0; errs = 0; seen_done = 0;
    end else begin
      if (o_busy) n_cyc++;
      if (o_done) begin n_done++; seen_done = 1; done_at = n_cyc; end
      if (bus.o_vram_req) begin
        n_req++;
        if (p_req && !p_val && bus.o_vram_addr != p_addr) errs++;
        if (bus.i_vram_valid && n_vlog < 32) begin vlog[n_vlog] = bus.o_vram_addr; n_vlog++; end
      end
      if (o_attr_we) begin
        if (o_slot != 3'(n_wa)) errs++;
        la[o_slot] = o_attr; lx[o_slot] = o_xcnt; n_wa++;
      end
      if (o_patt_we) begin lp[o_slot] = o_patt; n_wp++; end
      if (o_xcnt_wr != o_attr_we || (o_attr_we && o_patt_we) || o_patt_we != p_wa) errs++;
      if (!o_attr_we && (o_attr != p_attr || o_xcnt != p_xcnt)) errs++;
      if (!o_patt_we && o_patt != p_patt) errs++;
    end
    p_req = bus.o_vram_req; p_val = bus.i_vram_valid; p_addr = bus.o_vram_addr;
    p_wa = o_attr_we; p_attr = o_attr; p_xcnt = o_xcnt; p_patt = o_patt;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [3:0] c, input logic [7:0] l, input logic sz, input logic p,
                     input int d, input bit restart);
    spr_cnt = c; line = l; size = sz; pt = p; dly = d;
    @(posedge clk) #2 start = 1'b1;
    @(posedge clk) #2 start = 1'b0;
    for (int i = 0; i < 400 && !seen_done; i++) begin
      start = restart && i == 10;
      @(posedge clk) #2;
    end
    start = 1'b0;
    @(posedge clk) #2;
    chk("done_seen", seen_done, 1);
  endtask

  task automatic chk_empty(input int from);
    for (int k = from; k < 8; k++) begin
      chk($sformatf("empty_attr%0d", k), la[k], 8'h00);
      chk($sformatf("empty_xcnt%0d", k), lx[k], 8'hFF);
      chk($sformatf("empty_patt%0d", k), lp[k], 16'h0000);
    end
  endtask

  task automatic chk_one(input logic [13:0] a0, input logic [7:0] at, input logic [15:0] pa);
    chk("done_at", done_at, 24);
    chk("done_pulses", n_done, 1);
    chk("vram_reads", n_vlog, 2);
    chk("req_cycles", n_req, 2);
    chk("vaddr_lo", vlog[0], a0);
    chk("vaddr_hi", vlog[1], a0 + 14'd8);
    chk("attr0", la[0], at);
    chk("xcnt0", lx[0], 8'h30);
    chk("patt0", lp[0], pa);
    chk("wr_pairs", n_wa + n_wp, 16);
    chk("protocol", errs, 0);
    chk("busy_after", o_busy, 0);
    chk_empty(1);
  endtask

  task automatic chk_eight(input int exp_done);
    chk("done_at8", done_at, exp_done);
    chk("done_pulses8", n_done, 1);
    chk("vram_reads8", n_vlog, 16);
    chk("protocol8", errs, 0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("vlo%0d", k), vlog[2*k], 14'(32'h100 + 17*k));
      chk($sformatf("vhi%0d", k), vlog[2*k+1], 14'(32'h108 + 17*k));
      chk($sformatf("attr%0d", k), la[k], 8'(k));
      chk($sformatf("xcnt%0d", k), lx[k], 8'(16*k));
      chk($sformatf("patt%0d", k), lp[k], {8'(32'hF7 - 17*k), 8'(32'hFF - 17*k)});
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_req"}, bus.o_vram_req, 0);
    chk({tag, "_vaddr"}, bus.o_vram_addr, 0);
    chk({tag, "_saddr"}, bus.o_soam_addr, 0);
    chk({tag, "_slot"}, o_slot, 0);
    chk({tag, "_attr"}, o_attr, 0);
    chk({tag, "_xcnt"}, o_xcnt, 0);
    chk({tag, "_patt"}, o_patt, 0);
    chk({tag, "_strobes"}, {o_attr_we, o_xcnt_wr, o_patt_we}, 0);
  endtask

  initial begin
    bit hit;
    n_chk = 0; n_fail = 0; dly = 0;
    rstn = 1'b0; start = 1'b0; spr_cnt = '0; line = '0; size = 1'b0; pt = 1'b0;
    for (int i = 0; i < 32; i++) soam[i] = 8'h00;
    repeat (3) @(posedge clk);
    #2 chk_zero("rst");
    rstn = 1'b1;
    @(posedge clk) #2;
    // 8x8, row 3, pattern table 1
    soam[0] = 8'h0A; soam[1] = 8'h23; soam[2] = 8'h41; soam[3] = 8'h30;
    run(4'd1, 8'd13, 1'b0, 1'b1, 0, 1'b0);
    chk_one(14'h1233, 8'h41, 16'hC4CC);
    // vertical flip turns row 3 into row 4
    soam[2] = 8'h80;
    run(4'd1, 8'd13, 1'b0, 1'b1, 0, 1'b0);
    chk_one(14'h1234, 8'h80, 16'hC3CB);
    // 8x16, tile 0x25, row 9
    soam[0] = 8'h04; soam[1] = 8'h25; soam[2] = 8'h00;
    run(4'd1, 8'd13, 1'b1, 1'b0, 0, 1'b0);
    chk_one(14'h1251, 8'h00, 16'hA6AE);
    soam[2] = 8'h80;
    run(4'd1, 8'd13, 1'b1, 1'b0, 0, 1'b0);
    chk_one(14'h1246, 8'h80, 16'hB1B9);
    // no sprites
    run(4'd0, 8'd13, 1'b0, 1'b0, 0, 1'b0);
    chk("cnt0_done_at", done_at, 17);
    chk("cnt0_req", n_req, 0);
    chk("cnt0_pairs", n_wa + n_wp, 16);
    chk("cnt0_protocol", errs, 0);
    chk_empty(0);
    // eight sprites, count 12 clamps to 8, 3-cycle VRAM latency, stray start mid-run
    for (int k = 0; k < 8; k++) begin
      soam[4*k]   = 8'(20 - k);
      soam[4*k+1] = 8'(16 + k);
      soam[4*k+2] = 8'(k);
      soam[4*k+3] = 8'(16 * k);
    end
    run(4'd12, 8'd20, 1'b0, 1'b0, 3, 1'b1);
    chk_eight(121);
    chk("slow_req_cycles", n_req, 64);
    // reset during FETCH_H of slot 2
    spr_cnt = 4'd8; dly = 3;
    @(posedge clk) #2 start = 1'b1;
    @(posedge clk) #2 start = 1'b0;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk) #2;
      hit = n_vlog == 5 && bus.o_vram_req;
    end
    chk("reach_fetch_h2", hit, 1);
    rstn = 1'b0;
    @(posedge clk) #2 chk_zero("abort");
    rstn = 1'b1;
    @(posedge clk) #2;
    run(4'd8, 8'd20, 1'b0, 1'b0, 0, 1'b0);
    chk_eight(73);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ppu_spr_fetch.md
Name: ppu_spr_fetch

Overview:
- Per-scanline sprite fetch engine: the writer side of the eight sprite pixel-pipeline slots.
- On a start pulse at the beginning of HBLANK it walks secondary OAM slot by slot (0..7). For each slot it reads the 4 bytes, computes the pattern row address (8x8/8x16, vertical flip), and fetches both bitplanes from VRAM.
- It then loads that slot's xcnt, attribute and pattern registers.
- Unused slots are loaded as transparent.

Parameters:
- NUM_SLOTS, 8, number of sprite pipeline slots to load; slot index width is 3.

Ports:
- i_clk  in  1  PPU clock.
- i_rstn  in  1  async active-low reset.
- i_start  in  1  one-cycle pulse; begin fetch for the next line.
- i_spr_cnt  in  4  sprites found by evaluation (0..8); values >8 are treated as 8.
- i_scanline  in  8  line being prepared.
- i_spr_size  in  1  0 = 8x8, 1 = 8x16.
- i_spr_pt_sel  in  1  pattern table select for 8x8 sprites.
- o_soam_addr  out  5  secondary OAM read address.
- i_soam_data  in  8  secondary OAM data, valid 1 cycle after address.
- o_vram_req  out  1  VRAM read request.
- o_vram_addr  out  14  VRAM read address.
- i_vram_valid  in  1  read data valid; ends the request.
- i_vram_data  in  8  read data.
- o_slot  out  3  target slot index for the write strobes.
- o_xcnt  out  8  X count value.
- o_xcnt_wr  out  1  X count write strobe.
- o_attr  out  8  attribute byte.
- o_attr_we  out  1  attribute write strobe.
- o_patt  out  16  {plane1[7:0], plane0[7:0]}, unmirrored.
- o_patt_we  out  1  pattern write strobe.
- o_busy  out  1  high from the cycle after i_start until done.
- o_done  out  1  one-cycle pulse after the last slot's pattern write.

Behaviour:
- Reset: state IDLE; all strobes, o_vram_req, o_busy, o_done = 0; o_soam_addr, o_vram_addr, o_slot, o_xcnt, o_attr, o_patt = 0. Reset mid-operation aborts immediately; no further strobes.
- States: IDLE, SOAM, FETCH_L, FETCH_H, WR_A, WR_P, DONE.
- IDLE: on i_start, latch min(i_spr_cnt,8), i_scanline, i_spr_size and i_spr_pt_sel; set slot = 0; go to SOAM if slot < cnt, else WR_A.
- i_start while busy: ignored.
- SOAM (5 cycles):
  - o_soam_addr = {slot,2'd0}..{slot,2'd3} on 4 consecutive cycles.
  - Y, tile, attr and X are captured one cycle after their address.
  - Then go to FETCH_L.
- Row computation: row = (scanline - Y)[3:0], mod-256 subtract. Evaluation guarantees range; no check is made.
  - 8x8: r3 = row[2:0] (vflip attr[7]: 7 - row[2:0]); addr = {1'b0, pt_sel, tile, plane, r3}.
  - 8x16: r4 = row[3:0] (vflip: 15 - row); addr = {1'b0, tile[0], tile[7:1], r4[3], plane, r4[2:0]}.
- FETCH_L / FETCH_H:
  - Hold o_vram_req = 1 with plane = 0 / plane = 1 until i_vram_valid. i_vram_data is captured that cycle.
  - o_vram_req drops the next cycle; valid arriving in the same cycle as the request is legal.
  - Latency is unbounded; the engine waits.
- WR_A (1 cycle): o_attr_we = o_xcnt_wr = 1, o_slot = slot, o_attr = attr, o_xcnt = X.
- WR_P (1 cycle, always the cycle after WR_A): o_patt_we = 1, o_patt = {plane1, plane0}.
  - The slot applies X-mirroring from the attribute written the previous cycle. Attr must precede patt by at least 1 cycle.
- Empty slot (slot >= cnt): no SOAM or VRAM access. WR_A writes attr = 0x00, xcnt = 0xFF; WR_P writes patt = 0x0000.
- After WR_P: if slot == 7 go to DONE, else slot + 1 and back to SOAM or WR_A.
- DONE: o_done = 1 for one cycle, then IDLE.
- Strobe exclusivity: at most one of {WR_A strobes, o_patt_we} is high per cycle. o_xcnt, o_attr and o_patt hold their last values between strobes.
- Cycle counts with zero-wait VRAM (valid in the request cycle):
  - Filled slot = 5 + 1 + 1 + 2 = 9 cycles.
  - Empty slot = 2 cycles.
  - Total for cnt = n: 9n + 2(8 - n) + 1 (DONE).

Test Plan:
- 8x8 fetch, cnt=1, scanline=13, SOAM0 = {Y=0x0A, tile=0x23, attr=0x41, X=0x30}, pt_sel=1:
  - VRAM addrs 0x1233 then 0x123B.
  - Slot 0: attr_we with attr=0x41 and xcnt=0x30, then patt_we next cycle with {hi,lo}.
  - Slots 1..7 get xcnt=0xFF, patt=0; done after 9+14+1 cycles.
- Vertical flip, same case with attr=0x80 -> row 3 becomes 4 -> addrs 0x1234 / 0x123C.
- 8x16, tile=0x25, row=9 -> 0x1251 / 0x1259; with attr[7]=1 -> row 6, tile 0x24 -> 0x1246 / 0x124E.
- cnt=0 -> no o_vram_req and no SOAM reads; 8 WR_A/WR_P pairs to slots 0..7 in order; o_done at cycle 17.
- VRAM valid delayed 3 cycles on every read, cnt=8 -> o_vram_req held and the address stable throughout; data captured correctly; i_start pulsed mid-run is ignored.
- Assert reset during FETCH_H of slot 2 -> all outputs 0 next edge; after release, a new i_start yields a full correct sequence starting at slot 0.
